// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared constants, FSM encoding and helpers for mult_share_ctrl
//
// Purpose: operand width, default requester count and multiplier latency,
//          ceil-log2 helper for the requester ID width, and the flush FSM
//          state encoding shared by the top and the arbiter.
// Ports:   none (package).

package mult_share_pkg;

   localparam int W            = 18;
   localparam int DEF_NREQ     = 4;
   localparam int DEF_MULT_LAT = 5;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_DRAIN = 2'd1;
   localparam logic [1:0] ST_IDLE  = 2'd2;

   // Smallest r with 2**r >= value.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - rotating-priority one-hot arbiter with pointer register
//
// Purpose: grants at most one requester per cycle, searching from the
//          pointer upward with wrap; the pointer moves to one past the
//          winner after every grant and holds otherwise.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          arbitration enable; when low no grant is issued
//   req         per-requester request
//   gnt         one-hot grant (combinational)
//   gnt_id      index of the granted requester (valid when gnt_any)
//   gnt_any     a grant is issued this cycle

module rr_arbiter
   import mult_share_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = clog2(NREQ)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id,
   output logic            gnt_any
);

   // One extra bit so ptr+offset can exceed NREQ-1 before the wrap.
   localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

   logic [IDW-1:0] ptr;
   logic [IDW:0]   idx_w;
   logic [IDW-1:0] idx;
   logic [IDW:0]   nxt_w;

   always_comb begin
      gnt     = '0;
      gnt_id  = '0;
      gnt_any = 1'b0;
      idx_w   = '0;
      idx     = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx_w = {1'b0, ptr} + (IDW+1)'(k);
         if (idx_w >= NREQ_W) idx_w = idx_w - NREQ_W;
         idx = idx_w[IDW-1:0];
         if (en && !gnt_any && req[idx]) begin
            gnt[idx] = 1'b1;
            gnt_id   = idx;
            gnt_any  = 1'b1;
         end
      end
   end

   always_comb begin
      nxt_w = {1'b0, gnt_id} + (IDW+1)'(1);
      if (nxt_w >= NREQ_W) nxt_w = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (gnt_any) begin
         ptr <= nxt_w[IDW-1:0];
      end
   end

endmodule

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - shares one pipelined multiplier between NREQ requesters
//
// Purpose: round-robin issue of one operand pair per cycle into an external
//          fixed-latency multiplier, a valid/ID shadow pipe that returns each
//          product to its owner, and a flush/drain FSM for quiescing.
// Optional: define MULT_SHARE_CTRL_STATS_EN to add the stat_cnt result counter.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req                per-requester request, held with operands until granted
//   op_a, op_b         packed operands, requester i at [i*W +: W]
//   gnt                one-hot grant pulse (operands consumed this cycle)
//   mult_a, mult_b     registered multiplier operands
//   mult_p             multiplier product, MULT_LAT cycles after mult_a/mult_b
//   res_valid          product valid (no backpressure)
//   res_id, res_data   owning requester and full-width product
//   flush              level request to stop issuing and drain
//   flush_done         drained while flush is held
//   busy               any operation in flight
//   stat_cnt           (optional) saturating count of res_valid cycles

module mult_share_ctrl
   import mult_share_pkg::*;
#(
   parameter int NREQ     = DEF_NREQ,
   parameter int MULT_LAT = DEF_MULT_LAT,
   parameter int IDW      = clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] op_a,
   input  logic [NREQ*W-1:0] op_b,
   output logic [NREQ-1:0]   gnt,
   output logic [W-1:0]      mult_a,
   output logic [W-1:0]      mult_b,
   input  logic [2*W-1:0]    mult_p,
   output logic              res_valid,
   output logic [IDW-1:0]    res_id,
   output logic [2*W-1:0]    res_data,
   input  logic              flush,
   output logic              flush_done,
   output logic              busy
`ifdef MULT_SHARE_CTRL_STATS_EN
   ,
   output logic [31:0]       stat_cnt
`endif
);

   state_t         state;
   state_t         state_nxt;
   logic           arb_en;
   logic           gnt_any;
   logic [IDW-1:0] gnt_id;
   logic [W-1:0]   sel_a;
   logic [W-1:0]   sel_b;

   // Stage 0 lines up with mult_a/mult_b, stage MULT_LAT with mult_p.
   logic [MULT_LAT:0] sh_valid;
   logic [IDW-1:0]    sh_id [MULT_LAT+1];

   // Flush blocks the grant in the very cycle it is seen in RUN.
   assign arb_en = (state == ST_RUN) && !flush;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (arb_en),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_any (gnt_any)
   );

   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            sel_a = op_a[i*W +: W];
            sel_b = op_b[i*W +: W];
         end
      end
   end

   // Operands hold on idle cycles; the shadow valid marks them stale.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mult_a <= '0;
         mult_b <= '0;
      end else if (gnt_any) begin
         mult_a <= sel_a;
         mult_b <= sel_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_valid <= '0;
         for (int k = 0; k <= MULT_LAT; k++) sh_id[k] <= '0;
      end else begin
         sh_valid <= {sh_valid[MULT_LAT-1:0], gnt_any};
         sh_id[0] <= gnt_id;
         for (int k = 1; k <= MULT_LAT; k++) sh_id[k] <= sh_id[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_id    <= '0;
         res_data  <= '0;
      end else begin
         res_valid <= sh_valid[MULT_LAT];
         if (sh_valid[MULT_LAT]) begin
            res_id   <= sh_id[MULT_LAT];
            res_data <= mult_p;
         end
      end
   end

   assign busy = (|sh_valid) | res_valid;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN:   if (flush) state_nxt = ST_DRAIN;
         ST_DRAIN: begin
            if (!flush)     state_nxt = ST_RUN;
            else if (!busy) state_nxt = ST_IDLE;
         end
         ST_IDLE:  if (!flush) state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_RUN;
      end else begin
         state <= state_nxt;
      end
   end

   assign flush_done = (state == ST_IDLE);

`ifdef MULT_SHARE_CTRL_STATS_EN
   // Each flush starts a fresh count; clear wins over a coincident result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_cnt <= '0;
      end else if ((state == ST_RUN) && flush) begin
         stat_cnt <= '0;
      end else if (res_valid && (stat_cnt != 32'hFFFF_FFFF)) begin
         stat_cnt <= stat_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb/tb_mult_share_ctrl.sv - self-checking bench for mult_share_ctrl

module tb_mult_share_ctrl;

   localparam int NREQ = 4;
   localparam int W    = 18;
   localparam int LAT  = 5;
   localparam int IDW  = 2;

   localparam int M_RUN   = 0;
   localparam int M_DRAIN = 1;
   localparam int M_IDLE  = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NREQ-1:0]   req = '0;
   logic [NREQ*W-1:0] op_a = '0;
   logic [NREQ*W-1:0] op_b = '0;
   logic [NREQ-1:0]   gnt;
   logic [W-1:0]      mult_a;
   logic [W-1:0]      mult_b;
   logic [2*W-1:0]    mult_p;
   logic              res_valid;
   logic [IDW-1:0]    res_id;
   logic [2*W-1:0]    res_data;
   logic              flush = 1'b0;
   logic              flush_done;
   logic              busy;
`ifdef MULT_SHARE_CTRL_STATS_EN
   logic [31:0]       stat_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mult_share_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .op_a       (op_a),
      .op_b       (op_b),
      .gnt        (gnt),
      .mult_a     (mult_a),
      .mult_b     (mult_b),
      .mult_p     (mult_p),
      .res_valid  (res_valid),
      .res_id     (res_id),
      .res_data   (res_data),
      .flush      (flush),
      .flush_done (flush_done),
      .busy       (busy)
`ifdef MULT_SHARE_CTRL_STATS_EN
      ,
      .stat_cnt   (stat_cnt)
`endif
   );

   // External multiplier: product appears LAT cycles after its operands.
   logic [2*W-1:0] mpipe [LAT];
   always @(posedge clk) begin
      mpipe[0] <= 36'(mult_a) * 36'(mult_b);
      for (int k = 1; k < LAT; k++) mpipe[k] <= mpipe[k-1];
   end
   assign mult_p = mpipe[LAT-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      op_a[i*W +: W] = a;
      op_b[i*W +: W] = b;
   endtask

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 3))
         0:       return 18'h3FFFF;
         1:       return 18'h0;
         default: return W'($urandom);
      endcase
   endfunction

   // Behavioural model: results scheduled by cycle number, busy derived
   // from the age of the most recent grant.
   int             cyc      = 0;
   int             mptr     = 0;
   int             mstate   = M_RUN;
   int             last_gnt = -100;
   logic [W-1:0]   last_a   = '0;
   logic [W-1:0]   last_b   = '0;
   logic [2*W-1:0] sched_data [int];
   int             sched_id   [int];
   logic [31:0]    mstat    = '0;

   always @(negedge clk) begin : cmp
      logic [NREQ-1:0] eg;
      int              wi;
      int              age;
      logic            erv;
      if (!rst_n) begin
         chk("rst_gnt", gnt, 0);
         chk("rst_mult_a", mult_a, 0);
         chk("rst_mult_b", mult_b, 0);
         chk("rst_res_valid", res_valid, 0);
         chk("rst_res_id", res_id, 0);
         chk("rst_res_data", res_data, 0);
         chk("rst_flush_done", flush_done, 0);
         chk("rst_busy", busy, 0);
`ifdef MULT_SHARE_CTRL_STATS_EN
         chk("rst_stat", stat_cnt, 0);
`endif
         mptr     = 0;
         mstate   = M_RUN;
         last_gnt = -100;
         mstat    = '0;
         sched_data.delete();
         sched_id.delete();
      end else begin
         eg = '0;
         wi = -1;
         if (mstate == M_RUN && !flush) begin
            for (int k = 0; k < NREQ; k++) begin
               if (wi < 0 && req[(mptr + k) % NREQ]) wi = (mptr + k) % NREQ;
            end
         end
         if (wi >= 0) eg[wi] = 1'b1;
         chk("gnt", gnt, eg);

         erv = sched_data.exists(cyc);
         chk("res_valid", res_valid, erv);
         if (erv) begin
            chk("res_id", res_id, sched_id[cyc]);
            chk("res_data", res_data, sched_data[cyc]);
            sched_data.delete(cyc);
            sched_id.delete(cyc);
         end

         age = cyc - last_gnt;
         chk("busy", busy, (age >= 1 && age <= LAT + 2));
         chk("flush_done", flush_done, (mstate == M_IDLE));
         if (last_gnt == cyc - 1) begin
            chk("mult_a", mult_a, last_a);
            chk("mult_b", mult_b, last_b);
         end

`ifdef MULT_SHARE_CTRL_STATS_EN
         chk("stat_cnt", stat_cnt, mstat);
`endif
         if (mstate == M_RUN && flush) mstat = '0;
         else if (erv && mstat != 32'hFFFF_FFFF) mstat = mstat + 1;

         if (wi >= 0) begin
            last_a = op_a[wi*W +: W];
            last_b = op_b[wi*W +: W];
            sched_data[cyc + LAT + 2] = 36'(last_a) * 36'(last_b);
            sched_id[cyc + LAT + 2]   = wi;
            last_gnt = cyc;
            mptr     = (wi + 1) % NREQ;
         end

         case (mstate)
            M_RUN:   if (flush) mstate = M_DRAIN;
            M_DRAIN: begin
               if (!flush) mstate = M_RUN;
               else if (!(age >= 1 && age <= LAT + 2)) mstate = M_IDLE;
            end
            default: if (!flush) mstate = M_RUN;
         endcase
      end
      cyc++;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog time limit expired");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [NREQ-1:0] gs;
      int              rv_cnt;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("lit_rst_gnt", gnt, 0);
      chk("lit_rst_busy", busy, 0);
      chk("lit_rst_flush_done", flush_done, 0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (2) step();

      // All four requesting, operands i+1 and 2.
      for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 1), 18'd2);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         if (k > 0) step();
         @(negedge clk);
         chk("lit_rr_gnt", gnt, 64'(1) << (k % 4));
      end
      step();
      req = '0;
      for (int j = 5; j < 12; j++) begin
         if (j > 5) step();
         @(negedge clk);
         if (j >= 7) begin
            chk("lit_rr_valid", res_valid, 1);
            chk("lit_rr_id", res_id, (j - 7) % 4);
            chk("lit_rr_data", res_data, 2 * ((j - 7) % 4 + 1));
         end
      end

      // Single request from requester 1: 3 x 5.
      step();
      set_op(1, 18'd3, 18'd5);
      req = 4'b0010;
      @(negedge clk);
      chk("lit_single_gnt", gnt, 4'b0010);
      for (int j = 1; j <= 7; j++) begin
         step();
         if (j == 1) req = '0;
         @(negedge clk);
         if (j == 6) chk("lit_single_early", res_valid, 0);
         if (j == 7) begin
            chk("lit_single_valid", res_valid, 1);
            chk("lit_single_id", res_id, 1);
            chk("lit_single_data", res_data, 15);
         end
      end

      // Full-scale operands.
      step();
      set_op(0, 18'h3FFFF, 18'h3FFFF);
      req = 4'b0001;
      for (int j = 1; j <= 7; j++) begin
         step();
         if (j == 1) req = '0;
      end
      @(negedge clk);
      chk("lit_full_valid", res_valid, 1);
      chk("lit_full_data", res_data, 36'hFFFF80001);

      // Flush with three operations in flight.
      step();
      for (int i = 0; i < NREQ; i++) set_op(i, W'(i + 3), 18'd7);
      req = 4'b0111;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) step();
         @(negedge clk);
         chk("lit_pre_flush_gnt", gnt, (k == 0) ? 4'b0010 : (k == 1) ? 4'b0100 : 4'b0001);
      end
      rv_cnt = 0;
      for (int j = 3; j <= 12; j++) begin
         step();
         if (j == 3) begin
            flush = 1'b1;
            req   = 4'b1111;
         end
         @(negedge clk);
         chk("lit_flush_gnt", gnt, 0);
         if (res_valid) rv_cnt++;
         if (j == 10) chk("lit_flush_done_early", flush_done, 0);
         if (j == 11) chk("lit_flush_done", flush_done, 1);
      end
      chk("lit_flush_results", rv_cnt, 3);
      step();
      flush = 1'b0;
      req   = '0;
      step();

`ifdef MULT_SHARE_CTRL_STATS_EN
      // Ten results, then flush clears the counter.
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < NREQ; i++) set_op(i, rnd_op(), rnd_op());
      req = 4'b1111;
      repeat (10) step();
      req = '0;
      repeat (12) step();
      @(negedge clk);
      chk("lit_stat_ten", stat_cnt, 10);
      step();
      flush = 1'b1;
      @(negedge clk);
      chk("lit_stat_before_drain", stat_cnt, 10);
      step();
      @(negedge clk);
      chk("lit_stat_after_drain", stat_cnt, 0);
      step();
      flush = 1'b0;
      step();
`endif

      // Reset two cycles after a grant.
      set_op(0, 18'd9, 18'd9);
      req = 4'b0001;
      @(negedge clk);
      chk("lit_rstop_gnt", gnt, 4'b0001);
      step();
      req = '0;
      step();
      rst_n = 1'b0;
      @(negedge clk);
      chk("lit_rstop_mult_a", mult_a, 0);
      chk("lit_rstop_busy", busy, 0);
      chk("lit_rstop_valid", res_valid, 0);
      repeat (2) step();
      rst_n = 1'b1;
      for (int j = 0; j < 10; j++) begin
         step();
         @(negedge clk);
         chk("lit_rstop_no_res", res_valid, 0);
      end
      step();
      req = 4'b1111;
      @(negedge clk);
      chk("lit_rstop_ptr", gnt, 4'b0001);
      step();
      req = '0;

      // Random traffic with held requests and occasional flushes.
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         gs = gnt;
         step();
         for (int i = 0; i < NREQ; i++) begin
            if (req[i] && gs[i]) req[i] = 1'b0;
            if (!req[i] && $urandom_range(0, 99) < 40) begin
               req[i] = 1'b1;
               set_op(i, rnd_op(), rnd_op());
            end
         end
         if (flush) begin
            if ($urandom_range(0, 99) < 10) flush = 1'b0;
         end else if ($urandom_range(0, 99) < 2) begin
            flush = 1'b1;
         end
      end
      step();
      req   = '0;
      flush = 1'b0;
      repeat (20) step();
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
